// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback unit: FSM states, RV32I load
// encodings, the captured-load payload and the load legality helpers.
package wb_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
  localparam int unsigned XLEN                   = 32;
  localparam int unsigned REG_AW                 = 5;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Load attributes held while the memory read is outstanding
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic [1:0]        addr_lo;
  } ld_req_t;

  function automatic logic ld_illegal(input logic [2:0] funct3);
    return !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  endfunction

  function automatic logic ld_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_LH, F3_LHU: mis = addr_lo[0];
      F3_LW:         mis = (addr_lo != 2'd0);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Bundle of the ALU, load-issue, memory-response and register-file write
// signals seen by the writeback unit.
interface writeback_unit_if;
  import wb_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_result;

  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_rd;
  logic [2:0]        ld_funct3;
  logic [1:0]        ld_addr_lo;

  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  logic              write;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   reg_write;
  logic              stall;
  logic              err_misalign;
  logic              err_illegal;
  logic              err_timeout;

  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  ld_valid, ld_rd, ld_funct3, ld_addr_lo,
    input  mem_ack, mem_rdata,
    output alu_ready, ld_ready,
    output write, rd, reg_write, stall,
    output err_misalign, err_illegal, err_timeout
  );

  modport master (
    output alu_valid, alu_rd, alu_result,
    output ld_valid, ld_rd, ld_funct3, ld_addr_lo,
    output mem_ack, mem_rdata,
    input  alu_ready, ld_ready,
    input  write, rd, reg_write, stall,
    input  err_misalign, err_illegal, err_timeout
  );

endinterface

// File: rtl/writeback_unit_load_extend.sv
// Selects the addressed byte/half of an aligned memory word and sign- or
// zero-extends it according to the RV32I load type.
module load_extend
  import wb_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] value_c_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    value_c_o = rdata_i;
    case (funct3_i)
      F3_LB:   value_c_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   value_c_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  value_c_o = {24'd0, byte_sel};
      F3_LHU:  value_c_o = {16'd0, half_sel};
      default: value_c_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback stage: commits ALU results directly and RV32I loads
// after the memory response, with misalign/illegal/timeout error pulses.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  writeback_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  wb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ld_req_t           req_q, req_d;
  logic              write_q, write_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              err_mis_q, err_mis_d;
  logic              err_ill_q, err_ill_d;
  logic              err_to_q, err_to_d;
  logic [XLEN-1:0]   ld_value;

  load_extend u_load_extend (
    .funct3_i  (req_q.funct3),
    .addr_lo_i (req_q.addr_lo),
    .rdata_i   (bus.mem_rdata),
    .value_c_o (ld_value)
  );

  // Handshake readiness and stall follow the state directly
  assign bus.ld_ready  = (state_q == ST_IDLE);
  assign bus.alu_ready = (state_q == ST_IDLE) && !bus.ld_valid;
  assign bus.stall     = (state_q == ST_WAIT_MEM);

  assign bus.write        = write_q;
  assign bus.rd           = rd_q;
  assign bus.reg_write    = data_q;
  assign bus.err_misalign = err_mis_q;
  assign bus.err_illegal  = err_ill_q;
  assign bus.err_timeout  = err_to_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    write_d   = 1'b0;
    rd_d      = rd_q;
    data_d    = data_q;
    err_mis_d = 1'b0;
    err_ill_d = 1'b0;
    err_to_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.ld_valid) begin
          if (ld_illegal(bus.ld_funct3)) begin
            err_ill_d = 1'b1;
          end else if (ld_misaligned(bus.ld_funct3, bus.ld_addr_lo)) begin
            err_mis_d = 1'b1;
          end else begin
            req_d   = '{rd: bus.ld_rd, funct3: bus.ld_funct3, addr_lo: bus.ld_addr_lo};
            cnt_d   = '0;
            state_d = ST_WAIT_MEM;
          end
        end else if (bus.alu_valid && (bus.alu_rd != '0)) begin
          write_d = 1'b1;
          rd_d    = bus.alu_rd;
          data_d  = bus.alu_result;
        end
      end

      ST_WAIT_MEM: begin
        if (bus.mem_ack) begin
          state_d = ST_IDLE;
          if (req_q.rd != '0) begin
            write_d = 1'b1;
            rd_d    = req_q.rd;
            data_d  = ld_value;
          end
        end else begin
          // Abort once the number of ack-less wait cycles hits the limit
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            err_to_d = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      write_q   <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      err_mis_q <= 1'b0;
      err_ill_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      write_q   <= write_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      err_mis_q <= err_mis_d;
      err_ill_q <= err_ill_d;
      err_to_q  <= err_to_d;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_unit_if bus ();

  writeback_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus for the next cycle
  bit          s_rst, s_av, s_lv, s_ack;
  logic [4:0]  s_ard, s_lrd;
  logic [31:0] s_ares, s_rdata;
  logic [2:0]  s_f3;
  logic [1:0]  s_off;

  // Behavioural model: a pending-load record plus the expected output values
  bit          m_busy;
  int unsigned m_waited;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  logic        e_write, e_mis, e_ill, e_to;
  logic [4:0]  e_rd;
  logic [31:0] e_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  function automatic logic [31:0] ref_extend(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (32'(off) * 8)) & 32'hFF;
    h = (w >> (32'(off) * 8)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    e_write = 1'b0;
    e_mis   = 1'b0;
    e_ill   = 1'b0;
    e_to    = 1'b0;
    if (s_rst) begin
      m_busy   = 1'b0;
      m_waited = 0;
      e_rd     = '0;
      e_data   = '0;
    end else if (!m_busy) begin
      if (s_lv) begin
        if (s_f3 == 3'd3 || s_f3 >= 3'd6) e_ill = 1'b1;
        else if (((s_f3 == 3'd1 || s_f3 == 3'd5) && (s_off % 2 != 0)) ||
                 (s_f3 == 3'd2 && s_off != 0)) e_mis = 1'b1;
        else begin
          m_busy   = 1'b1;
          m_waited = 0;
          m_rd     = s_lrd;
          m_f3     = s_f3;
          m_off    = s_off;
        end
      end else if (s_av && s_ard != 0) begin
        e_write = 1'b1;
        e_rd    = s_ard;
        e_data  = s_ares;
      end
    end else if (s_ack) begin
      m_busy = 1'b0;
      if (m_rd != 0) begin
        e_write = 1'b1;
        e_rd    = m_rd;
        e_data  = ref_extend(m_f3, m_off, s_rdata);
      end
    end else begin
      m_waited++;
      if (m_waited == TO) begin
        e_to   = 1'b1;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic idle_inputs();
    s_rst = 0; s_av = 0; s_lv = 0; s_ack = 0;
    s_ard = '0; s_lrd = '0; s_ares = '0; s_rdata = '0; s_f3 = '0; s_off = '0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs
  task automatic step();
    rst            = s_rst;
    bus.alu_valid  = s_av;
    bus.alu_rd     = s_ard;
    bus.alu_result = s_ares;
    bus.ld_valid   = s_lv;
    bus.ld_rd      = s_lrd;
    bus.ld_funct3  = s_f3;
    bus.ld_addr_lo = s_off;
    bus.mem_ack    = s_ack;
    bus.mem_rdata  = s_rdata;
    #1;
    chk1("alu_ready", bus.alu_ready, !m_busy && !s_lv);
    chk1("ld_ready", bus.ld_ready, !m_busy);
    chk1("stall_pre", bus.stall, m_busy);
    @(posedge clk);
    model_step();
    #1;
    chk1("write", bus.write, e_write);
    chk("rd", 32'(bus.rd), 32'(e_rd));
    chk("reg_write", bus.reg_write, e_data);
    chk1("err_misalign", bus.err_misalign, e_mis);
    chk1("err_illegal", bus.err_illegal, e_ill);
    chk1("err_timeout", bus.err_timeout, e_to);
    chk1("stall", bus.stall, m_busy);
  endtask

  initial begin
    idle_inputs();
    s_rst = 1;
    rst = 1'b1;
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_result = '0;
    bus.ld_valid = 0; bus.ld_rd = '0; bus.ld_funct3 = '0; bus.ld_addr_lo = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    m_busy = 0; m_waited = 0; m_rd = '0; m_f3 = '0; m_off = '0;
    e_write = 0; e_mis = 0; e_ill = 0; e_to = 0; e_rd = '0; e_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    step();
    chk1("lit_rst_write", bus.write, 1'b0);
    chk("lit_rst_rd", 32'(bus.rd), 32'd0);
    chk("lit_rst_data", bus.reg_write, 32'd0);

    // ALU commit, then hold
    idle_inputs(); s_av = 1; s_ard = 5'd5; s_ares = 32'hDEADBEEF; step();
    chk1("lit_alu_write", bus.write, 1'b1);
    chk("lit_alu_rd", 32'(bus.rd), 32'd5);
    chk("lit_alu_data", bus.reg_write, 32'hDEADBEEF);
    idle_inputs(); step();
    chk1("lit_hold_write", bus.write, 1'b0);
    chk("lit_hold_data", bus.reg_write, 32'hDEADBEEF);

    // LB / LBU at offset 1
    idle_inputs(); s_lv = 1; s_lrd = 5'd3; s_f3 = F3_LB; s_off = 2'd1; step();
    chk1("lit_lb_stall", bus.stall, 1'b1);
    idle_inputs(); s_ack = 1; s_rdata = 32'h0000_80FF; step();
    chk("lit_lb_rd", 32'(bus.rd), 32'd3);
    chk("lit_lb_data", bus.reg_write, 32'hFFFFFF80);
    idle_inputs(); s_lv = 1; s_lrd = 5'd3; s_f3 = F3_LBU; s_off = 2'd1; step();
    idle_inputs(); s_ack = 1; s_rdata = 32'h0000_80FF; step();
    chk("lit_lbu_data", bus.reg_write, 32'h00000080);

    // Simultaneous ALU and load: load wins, ALU accepted right after the commit
    idle_inputs(); s_av = 1; s_ard = 5'd7; s_ares = 32'h1234; s_lv = 1; s_lrd = 5'd4; s_f3 = F3_LW; step();
    chk1("lit_sim_stall", bus.stall, 1'b1);
    chk1("lit_sim_alu_ready", bus.alu_ready, 1'b0);
    idle_inputs(); s_av = 1; s_ard = 5'd7; s_ares = 32'h1234; step();
    idle_inputs(); s_av = 1; s_ard = 5'd7; s_ares = 32'h1234; s_ack = 1; s_rdata = 32'hCAFEF00D; step();
    chk("lit_sim_ld_data", bus.reg_write, 32'hCAFEF00D);
    idle_inputs(); s_av = 1; s_ard = 5'd7; s_ares = 32'h1234; step();
    chk("lit_sim_alu_rd", 32'(bus.rd), 32'd7);
    chk("lit_sim_alu_data", bus.reg_write, 32'h1234);

    // Misaligned and illegal loads
    idle_inputs(); s_lv = 1; s_lrd = 5'd8; s_f3 = F3_LW; s_off = 2'd2; step();
    chk1("lit_mis_pulse", bus.err_misalign, 1'b1);
    chk1("lit_mis_stall", bus.stall, 1'b0);
    idle_inputs(); s_lv = 1; s_lrd = 5'd8; s_f3 = 3'd3; s_off = 2'd1; step();
    chk1("lit_ill_pulse", bus.err_illegal, 1'b1);
    chk1("lit_ill_no_mis", bus.err_misalign, 1'b0);

    // Timeout after TO ack-less cycles
    idle_inputs(); s_lv = 1; s_lrd = 5'd9; s_f3 = F3_LW; step();
    for (int unsigned i = 0; i < TO - 1; i++) begin
      idle_inputs(); step();
    end
    chk1("lit_to_still_waiting", bus.stall, 1'b1);
    idle_inputs(); step();
    chk1("lit_to_pulse", bus.err_timeout, 1'b1);
    chk1("lit_to_stall", bus.stall, 1'b0);
    chk1("lit_to_write", bus.write, 1'b0);

    // Load to x0
    idle_inputs(); s_lv = 1; s_lrd = 5'd0; s_f3 = F3_LW; step();
    idle_inputs(); s_ack = 1; s_rdata = 32'h55AA55AA; step();
    chk1("lit_x0_write", bus.write, 1'b0);

    // Reset during WAIT_MEM, then late ack
    idle_inputs(); s_lv = 1; s_lrd = 5'd6; s_f3 = F3_LW; step();
    idle_inputs(); s_rst = 1; step();
    idle_inputs(); s_ack = 1; s_rdata = 32'h11223344; step();
    chk1("lit_rstw_write", bus.write, 1'b0);
    chk1("lit_rstw_stall", bus.stall, 1'b0);
    chk("lit_rstw_rd", 32'(bus.rd), 32'd0);
    chk("lit_rstw_data", bus.reg_write, 32'd0);

    // Randomized traffic; the second half starves acks to provoke timeouts
    for (int i = 0; i < 3000; i++) begin
      idle_inputs();
      s_rst   = ($urandom_range(0, 149) == 0);
      s_av    = 1'($urandom_range(0, 1));
      s_ard   = 5'($urandom);
      s_ares  = $urandom;
      s_lv    = ($urandom_range(0, 9) < 3);
      s_lrd   = 5'($urandom);
      s_f3    = 3'($urandom);
      s_off   = 2'($urandom);
      s_ack   = (i < 1500) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
      s_rdata = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
